// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM states,
// major opcodes, ALU operation selects, trap causes and the control bundle.
package riscv_ctrl_pkg;

    // 3-bit encoding leaves one spare code; the FSM maps it back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation selects
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Trap causes
    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_IMEM    = 2'b10;
    localparam logic [1:0] TC_DMEM    = 2'b11;

    // One bundle for every datapath/memory strobe the FSM drives
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without ready and flags
// expiry on the MEM_TIMEOUT-th such cycle so the FSM traps on that edge.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    // The count holds the number of wait cycles already completed, so the
    // current wait cycle is the last allowed one when count == limit-1.
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt;
    logic       waiting;

    assign waiting = req && !ready && !clear;
    assign expired = waiting && (cnt == LIMIT);

    // Restart on ready, on a dropped request, on leaving the state, or once
    // expiry has been reported
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!waiting || expired)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback with
// memory wait timeouts, illegal-opcode trap and a retired-instruction count.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);

    state_e     state;
    logic [6:0] op_q;
    ctrl_t      ctrl;
    logic       tmr_req;
    logic       tmr_ready;
    logic       tmr_clear;
    logic       tmr_expired;
    logic       op_load;
    logic       op_store;

    assign op_load  = (op_q == OP_LOAD);
    assign op_store = (op_q == OP_STORE);

    // One timer serves both memories: only one request can be open at a time
    assign tmr_req   = ctrl.imem_req | ctrl.dmem_req;
    assign tmr_ready = (state == ST_FETCH) ? imem_ready : dmem_ready;
    assign tmr_clear = (state != ST_FETCH) && (state != ST_MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .req     (tmr_req),
        .ready   (tmr_ready),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    // Strobes decode from the registered state; ready and zero feed through
    // so handshakes complete in the same cycle and reset kills them at once
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.imem_req = 1'b1;
                ctrl.ir_write = imem_ready;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_R: begin
                        ctrl.alu_src = 1'b0;
                        ctrl.alu_op  = ALU_FUNCT;
                    end
                    OP_I: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                    end
                    OP_BRANCH: begin
                        ctrl.alu_src  = 1'b0;
                        ctrl.alu_op   = ALU_SUB;
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = zero;
                    end
                    default: ctrl = '0;
                endcase
            end
            ST_MEM: begin
                ctrl.dmem_req = 1'b1;
                ctrl.dmem_we  = op_store;
                ctrl.pc_write = op_store && dmem_ready;
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = op_load;
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign imem_req   = ctrl.imem_req;
    assign dmem_req   = ctrl.dmem_req;
    assign dmem_we    = ctrl.dmem_we;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src    = ctrl.alu_src;
    assign alu_op     = ctrl.alu_op;

    assign busy = (state != ST_IDLE) && (state != ST_TRAP);

    // Sequencer: state transitions, opcode capture, trap status and the
    // retired count (one per pc_write, i.e. one per completed instruction)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            trap       <= 1'b0;
            trap_cause <= TC_NONE;
            retired    <= '0;
        end else begin
            if (ctrl.pc_write)
                retired <= retired + RETIRE_W'(1);

            case (state)
                ST_IDLE: begin
                    if (run)
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        state <= ST_DECODE;
                    end else if (tmr_expired) begin
                        state      <= ST_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TC_IMEM;
                    end
                end
                ST_DECODE: begin
                    op_q <= opcode;
                    if (is_legal_op(opcode)) begin
                        state <= ST_EXEC;
                    end else begin
                        state      <= ST_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TC_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_R, OP_I:         state <= ST_WB;
                        OP_LOAD, OP_STORE:  state <= ST_MEM;
                        OP_BRANCH:          state <= run ? ST_FETCH : ST_IDLE;
                        default:            state <= ST_IDLE;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (op_store)
                            state <= run ? ST_FETCH : ST_IDLE;
                        else
                            state <= ST_WB;
                    end else if (tmr_expired) begin
                        state      <= ST_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TC_DMEM;
                    end
                end
                ST_WB: begin
                    state <= run ? ST_FETCH : ST_IDLE;
                end
                ST_TRAP: begin
                    // Held until software drops run, acknowledging the trap
                    if (!run) begin
                        state      <= ST_IDLE;
                        trap       <= 1'b0;
                        trap_cause <= TC_NONE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    trap       <= 1'b0;
                    trap_cause <= TC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed table of instructions, random
// instruction stream against an instruction-level model, plus reset cases.
module tb_multicycle_controller;

    localparam int T = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
    logic        reg_write, mem_to_reg, alu_src, busy, trap;
    logic [1:0]  alu_op, trap_cause;
    logic [31:0] retired;

    multicycle_controller #(.MEM_TIMEOUT(T), .RETIRE_W(32)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_op(alu_op), .busy(busy), .trap(trap), .trap_cause(trap_cause),
        .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] opcode;
        logic       zero;
        int         di;     // imem wait cycles before ready
        int         dd;     // dmem wait cycles before ready
        logic       drop;   // drop run during the instruction
    } stim_t;

    typedef struct {
        int         cycles;
        int         imem_cnt;
        int         ir_cnt;
        int         dmem_cnt;
        int         we_cnt;
        int         rw_cnt;
        int         m2r_cnt;
        int         pcw_cnt;
        logic       pc_src;
        logic [1:0] cause;
        logic [1:0] alu_op;
        logic       alu_src;
    } res_t;

    typedef struct {
        stim_t s;
        res_t  e;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_retired = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic legal(input logic [6:0] op);
        logic [6:0] ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Instruction-level model: cycle counts follow from the per-class phase
    // sequence (fetch, decode, execute, optional memory, optional writeback)
    function automatic res_t model(input stim_t s);
        res_t r;
        r = '{default: 0};
        if (s.di >= T) begin
            r.cycles = T; r.imem_cnt = T; r.cause = 2'b10;
            return r;
        end
        r.imem_cnt = s.di + 1;
        r.ir_cnt   = 1;
        case (s.opcode)
            7'b0110011: begin r.cycles = s.di + 4; r.rw_cnt = 1; r.pcw_cnt = 1; r.alu_op = 2'b10; r.alu_src = 0; end
            7'b0010011: begin r.cycles = s.di + 4; r.rw_cnt = 1; r.pcw_cnt = 1; r.alu_op = 2'b10; r.alu_src = 1; end
            7'b1100011: begin r.cycles = s.di + 3; r.pcw_cnt = 1; r.pc_src = s.zero; r.alu_op = 2'b01; r.alu_src = 0; end
            7'b0000011, 7'b0100011: begin
                r.alu_op = 2'b00; r.alu_src = 1;
                if (s.dd >= T) begin
                    r.dmem_cnt = T;
                    r.we_cnt   = (s.opcode == 7'b0100011) ? T : 0;
                    r.cycles   = s.di + 3 + T;
                    r.cause    = 2'b11;
                end else begin
                    r.dmem_cnt = s.dd + 1;
                    r.pcw_cnt  = 1;
                    if (s.opcode == 7'b0100011) begin
                        r.we_cnt = s.dd + 1;
                        r.cycles = s.di + 4 + s.dd;
                    end else begin
                        r.rw_cnt = 1; r.m2r_cnt = 1;
                        r.cycles = s.di + 5 + s.dd;
                    end
                end
            end
            default: begin r.cycles = s.di + 2; r.cause = 2'b01; end
        endcase
        return r;
    endfunction

    // Drive one instruction starting in FETCH; stop at its pc_write or a trap
    task automatic run_instr(input stim_t s, output res_t r, output bit trapped);
        int  iw, dw, cyc, kf;
        bit  done;
        r = '{default: 0};
        iw = 0; dw = 0; cyc = 0; kf = -10; done = 0; trapped = 0;
        opcode = s.opcode;
        zero   = s.zero;
        while (!done && cyc < 200) begin
            @(negedge clock);
            imem_ready = imem_req && (iw == s.di);
            dmem_ready = dmem_req && (dw == s.dd);
            run        = !(s.drop && cyc >= 1);
            #1;
            if (imem_req) begin r.imem_cnt += 1; iw++; end
            if (dmem_req) begin r.dmem_cnt += 1; dw++; end
            if (dmem_we)    r.we_cnt += 1;
            if (reg_write)  r.rw_cnt += 1;
            if (mem_to_reg) r.m2r_cnt += 1;
            if (ir_write) begin r.ir_cnt += 1; kf = cyc; end
            if (cyc == kf + 2) begin r.alu_op = alu_op; r.alu_src = alu_src; end
            if (pc_write) begin r.pcw_cnt += 1; r.pc_src = pc_src; done = 1; end
            cyc++;
            @(posedge clock); #1;
            if (trap) begin trapped = 1; r.cause = trap_cause; done = 1; end
        end
        r.cycles = cyc;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL instr_timeout: got no completion within %0d cycles", cyc);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t e);
        chk({tag, ".cycles"},     a.cycles,   e.cycles);
        chk({tag, ".imem_req"},   a.imem_cnt, e.imem_cnt);
        chk({tag, ".ir_write"},   a.ir_cnt,   e.ir_cnt);
        chk({tag, ".dmem_req"},   a.dmem_cnt, e.dmem_cnt);
        chk({tag, ".dmem_we"},    a.we_cnt,   e.we_cnt);
        chk({tag, ".reg_write"},  a.rw_cnt,   e.rw_cnt);
        chk({tag, ".mem_to_reg"}, a.m2r_cnt,  e.m2r_cnt);
        chk({tag, ".pc_write"},   a.pcw_cnt,  e.pcw_cnt);
        chk({tag, ".pc_src"},     a.pc_src,   e.pc_src);
        chk({tag, ".cause"},      a.cause,    e.cause);
        chk({tag, ".alu_op"},     a.alu_op,   e.alu_op);
        chk({tag, ".alu_src"},    a.alu_src,  e.alu_src);
    endtask

    // Run, compare, then bring the FSM back to FETCH (trap ack / run restart)
    task automatic do_instr(input string tag, input stim_t s, input res_t e);
        res_t r;
        bit   trapped;
        run_instr(s, r, trapped);
        cmp_res(tag, r, e);
        exp_retired += 32'(e.pcw_cnt);
        chk({tag, ".retired"}, retired, exp_retired);
        if (trapped) begin
            chk({tag, ".trap_busy"}, busy, 0);
            @(negedge clock); run = 0; imem_ready = 0; dmem_ready = 0;
            @(posedge clock); #1;
            chk({tag, ".trap_clr"}, trap, 0);
            chk({tag, ".cause_clr"}, trap_cause, 0);
            chk({tag, ".idle_busy"}, busy, 0);
            @(negedge clock); run = 1;
            @(posedge clock); #1;
        end else if (s.drop) begin
            chk({tag, ".stop_busy"}, busy, 0);
            @(negedge clock); run = 1; imem_ready = 0; dmem_ready = 0;
            @(posedge clock); #1;
        end
        chk({tag, ".fetch"}, imem_req, 1);
    endtask

    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        //                opcode        z  di  dd drop    cyc im ir dm we rw m2r pcw pcs cause   aluop  src
        tbl[0] = '{'{7'b0110011, 0, 0,  0, 0}, '{ 4, 1, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b10, 0}};
        tbl[1] = '{'{7'b1100011, 1, 0,  0, 0}, '{ 3, 1, 1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0}};
        tbl[2] = '{'{7'b1100011, 0, 0,  0, 0}, '{ 3, 1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0}};
        tbl[3] = '{'{7'b0000011, 0, 0,  5, 0}, '{10, 1, 1, 6, 0, 1, 1, 1, 0, 2'b00, 2'b00, 1}};
        tbl[4] = '{'{7'b0110011, 0, 99, 0, 0}, '{15,15, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0}};
        tbl[5] = '{'{7'b1111111, 0, 0,  0, 0}, '{ 2, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0}};
        tbl[6] = '{'{7'b0100011, 0, 2,  3, 0}, '{ 9, 3, 1, 4, 4, 0, 0, 1, 0, 2'b00, 2'b00, 1}};
        tbl[7] = '{'{7'b0010011, 0, 0,  0, 1}, '{ 4, 1, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b10, 1}};
        tbl[8] = '{'{7'b0100011, 0, 0, 99, 0}, '{18, 1, 1,15,15, 0, 0, 0, 0, 2'b11, 2'b00, 1}};
        tbl[9] = '{'{7'b0010011, 0, 14, 0, 0}, '{18,15, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b10, 1}};

        // Reset state
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.trap", trap, 0);
        chk("rst.cause", trap_cause, 0);
        chk("rst.retired", retired, 0);
        chk("rst.strobes", {imem_req, dmem_req, pc_write, reg_write, ir_write}, 0);
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        chk("idle.hold", imem_req, 0);
        @(negedge clock); run = 1;
        #1 chk("idle.pre_fetch", imem_req, 0);
        @(posedge clock); #1;
        chk("idle.fetch", imem_req, 1);

        // Directed table
        for (int i = 0; i < 10; i++)
            do_instr($sformatf("tbl%0d", i), tbl[i].s, tbl[i].e);

        // Random instruction stream against the model
        for (int i = 0; i < 60; i++) begin
            stim_t s;
            logic [6:0] ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
            int k;
            k = $urandom_range(0, 5);
            if (k < 5) s.opcode = ops[k];
            else begin
                s.opcode = 7'($urandom);
                if (legal(s.opcode)) s.opcode = 7'b1111111;
            end
            s.zero = 1'($urandom);
            k = $urandom_range(0, 19);
            s.di = (k == 0) ? T : (k == 1) ? T - 1 : $urandom_range(0, 3);
            k = $urandom_range(0, 19);
            s.dd = (k == 0) ? T : (k == 1) ? T - 1 : $urandom_range(0, 4);
            s.drop = ($urandom_range(0, 4) == 0);
            do_instr($sformatf("rnd%0d", i), s, model(s));
        end

        // Reset while a store waits in MEM: strobes drop at once, no retire
        @(negedge clock);
        opcode = 7'b0100011; imem_ready = 1; dmem_ready = 0; run = 1;
        @(posedge clock);
        @(negedge clock); imem_ready = 0;
        @(posedge clock);
        @(posedge clock); #1;
        chk("rstmem.dmem_req_before", dmem_req, 1);
        @(negedge clock); #2;
        reset = 0;
        #1;
        chk("rstmem.dmem_req", dmem_req, 0);
        chk("rstmem.pc_write", pc_write, 0);
        chk("rstmem.retired", retired, 0);
        chk("rstmem.busy", busy, 0);
        dmem_ready = 1;
        @(posedge clock); #1;
        chk("rstmem.pc_write_edge", pc_write, 0);
        chk("rstmem.retired_edge", retired, 0);
        chk("rstmem.dmem_req_edge", dmem_req, 0);
        @(negedge clock); reset = 1; dmem_ready = 0; run = 0;
        @(posedge clock); #1;
        chk("rstmem.idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, maximum cycles a request may wait for ready before a trap (1..255).
REQ-002 Parameter: RETIRE_W, 32, width of the retired-instruction counter.
REQ-003 Clock/reset: one clock `clock`, sampled on its rising edge; reset `reset` is asynchronous and active-low.
REQ-004 clock  in  1  system clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-007 opcode  in  7  instruction[6:0] from the instruction register.
REQ-008 zero  in  1  ALU Zero flag.
REQ-009 imem_ready / dmem_ready  in  1 each  memory completion strobes.
REQ-010 imem_req, dmem_req, dmem_we  out  1 each  memory requests; dmem_we = store.
REQ-011 ir_write, pc_write, pc_src  out  1 each  IR load, PC load, PC select (0 = PC+4, 1 = PC+(imm<<1)).
REQ-012 reg_write, mem_to_reg, alu_src  out  1 each  datapath controls.
REQ-013 alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-014 busy, trap  out  1 each; trap_cause  out  2  (01 illegal opcode, 10 imem timeout, 11 dmem timeout).
REQ-015 retired  out  RETIRE_W  count of completed instructions.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-017 IDLE: all strobes SHALL be 0; run=1 SHALL move the FSM to FETCH on the next edge.
REQ-018 FETCH: imem_req SHALL be 1 until imem_ready; in the ready cycle ir_write SHALL be 1 and the next state SHALL be DECODE.
REQ-019 DECODE: the opcode SHALL be registered; legal values are 0110011, 0010011, 0000011, 0100011 and 1100011; legal → EXEC, else → TRAP with cause 01.
REQ-020 EXEC for R-type: alu_src=0, alu_op=10, next state WB.
REQ-021 EXEC for I-ALU: alu_src=1, alu_op=10, next state WB.
REQ-022 EXEC for load/store: alu_src=1, alu_op=00, next state MEM.
REQ-023 EXEC for branch: alu_src=0, alu_op=01, pc_write=1, pc_src=zero (Mealy), instruction retires, next state FETCH or IDLE.
REQ-024 MEM: dmem_req SHALL be 1 until dmem_ready, with dmem_we=1 for stores.
REQ-025 MEM, dmem_ready cycle: a store SHALL assert pc_write=1 with pc_src=0, retire, and go to FETCH or IDLE; a load SHALL go to WB.
REQ-026 WB: reg_write=1, mem_to_reg=1 only for loads, pc_write=1, pc_src=0, instruction retires, next state FETCH or IDLE.
REQ-027 Instruction boundary: the exit from an instruction SHALL go to IDLE when run=0, else to FETCH.
REQ-028 run deasserted mid-instruction SHALL NOT abort the instruction.
REQ-029 Minimum latency with ready=1 in the request cycle: branch 3 cycles, R/I/store 4, load 5.
REQ-030 Wait timer: a counter SHALL count consecutive cycles with a request high and its ready low.
REQ-031 The wait timer SHALL clear on ready or on state exit; reaching MEM_TIMEOUT SHALL enter TRAP with cause 10 or 11.
REQ-032 TRAP: trap=1 and trap_cause SHALL be held, all strobes 0; exit to IDLE only when run=0, then trap and trap_cause clear.
REQ-033 retired SHALL increment by 1 per pc_write cycle and wrap modulo 2^RETIRE_W.
REQ-034 busy SHALL be 1 in every state except IDLE and TRAP.
REQ-035 Unused or illegal internal state encodings SHALL recover to IDLE.

Reset
REQ-036 reset=0 SHALL immediately force IDLE, trap=0, trap_cause=00, retired=0, wait timer=0, registered opcode=0 and all strobes 0, including mid-request.
REQ-037 After reset release, the first FETCH SHALL occur on the edge after run is sampled 1.

Structure
REQ-038 A shared package riscv_ctrl_pkg SHALL hold the state enum, opcode constants, alu_op encodings and trap_cause encodings.
REQ-039 The wait timer SHALL be a sub-module named mem_wait_timer (inputs: req, ready, clear; output: expired; parameter MEM_TIMEOUT).

Verification
REQ-040 Scenario: R-type 0110011, ready=1 always, run=1 → FETCH-DECODE-EXEC-WB, one reg_write pulse, retired 0→1 after 4 cycles.
REQ-041 Scenario: branch 1100011 with zero=1, then zero=0 → pc_src=1 and then 0 in EXEC, pc_write each time, 3 cycles per instruction.
REQ-042 Scenario: load with dmem_ready delayed 5 cycles → dmem_req high 6 cycles, then WB with mem_to_reg=1, 10 cycles total.
REQ-043 Scenario: imem_ready held 0, MEM_TIMEOUT=15 → TRAP after 15 wait cycles, trap_cause=10; run=0 → IDLE with trap cleared.
REQ-044 Scenario: opcode 1111111 → TRAP cause 01, retired unchanged.
REQ-045 Scenario: reset=0 asserted during MEM of a store → dmem_req drops asynchronously, retired=0, and no pc_write occurs.
